smem_store_unit: RTL and testbench

//   Store-side counterpart of the load-data extractor: takes SB/SH/SW from the MEM stage and

---
 rtl/smem_store_unit.sv | 150 +++++++++++++++
 tb/tb_smem_store_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smem_store_unit.sv
// MEM-stage store unit: builds big-endian byte lanes, strobes and size for SB/SH/SW,
// flags misaligned stores and runs the req/addr_ok/data_ok write handshake.
module smem_store_unit #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter logic [7:0]  SB_CONTROL = 8'h28,
    parameter logic [7:0]  SH_CONTROL = 8'h29,
    parameter logic [7:0]  SW_CONTROL = 8'h2B
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          store_validM,
    input  logic [7:0]    alucontrolM,
    input  logic [AW-1:0] addrM,
    input  logic [DW-1:0] writedataM,
    input  logic          flushM,
    output logic          saddrerrM,
    output logic [AW-1:0] badvaddrM,
    output logic          stall_st,
    output logic          st_done,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    output logic [3:0]    data_wstrb,
    input  logic          data_addr_ok,
    input  logic          data_data_ok
);

    localparam int unsigned NLANE = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]       size;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    wdata;
        logic [NLANE-1:0] wstrb;
    } wr_req_t;

    state_t  state_q, state_d;
    wr_req_t req_q, req_c;
    logic    done_q, done_d;
    logic    load_c;
    logic    stall_c;
    logic    is_sb_c, is_sh_c, is_sw_c, is_store_c;
    logic    misalign_c;
    logic    start_c;

    // Opcode decode and alignment check
    assign is_sb_c    = (alucontrolM == SB_CONTROL);
    assign is_sh_c    = (alucontrolM == SH_CONTROL);
    assign is_sw_c    = (alucontrolM == SW_CONTROL);
    assign is_store_c = is_sb_c | is_sh_c | is_sw_c;
    assign misalign_c = (is_sh_c & addrM[0]) | (is_sw_c & (addrM[1:0] != 2'b00));

    assign saddrerrM  = store_validM & is_store_c & misalign_c & ~flushM;
    assign badvaddrM  = saddrerrM ? addrM : '0;
    assign start_c    = (state_q == S_IDLE) & store_validM & is_store_c & ~misalign_c & ~flushM;

    // Big-endian lane placement: address offset 0 is the most significant byte
    always_comb begin
        req_c.addr  = addrM;
        req_c.size  = 2'd0;
        req_c.wdata = DW'({4{writedataM[7:0]}});
        req_c.wstrb = NLANE'(4'b1000 >> addrM[1:0]);
        if (is_sw_c) begin
            req_c.size  = 2'd2;
            req_c.wdata = writedataM;
            req_c.wstrb = '1;
        end else if (is_sh_c) begin
            req_c.size  = 2'd1;
            req_c.wdata = DW'({2{writedataM[15:0]}});
            req_c.wstrb = addrM[1] ? NLANE'(4'b0011) : NLANE'(4'b1100);
        end
    end

    // Handshake FSM; a write accepted by the bus is always allowed to finish
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load_c  = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_REQ;
                    load_c  = 1'b1;
                    stall_c = 1'b1;
                end
            end
            S_REQ: begin
                if (data_addr_ok & data_data_ok) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    stall_c = ~flushM;
                    if (data_addr_ok) begin
                        state_d = S_WAIT;
                    end else if (flushM) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rst) begin
            stall_c = start_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load_c) begin
                req_q <= req_c;
            end
        end
    end

    assign stall_st   = stall_c;
    assign st_done    = done_q;
    assign data_req   = (state_q == S_REQ);
    assign data_wr    = data_req;
    assign data_size  = req_q.size;
    assign data_addr  = req_q.addr;
    assign data_wdata = req_q.wdata;
    assign data_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_smem_store_unit.sv
// Bench for smem_store_unit: directed scenarios with literal expectations plus a
// randomized run, all cycles compared against a transaction-level model.
module tb_smem_store_unit;

    localparam logic [7:0] OP_SB = 8'h28;
    localparam logic [7:0] OP_SH = 8'h29;
    localparam logic [7:0] OP_SW = 8'h2B;
    localparam logic [7:0] OP_NO = 8'h21;

    logic        clk;
    logic        rst;
    logic        store_validM;
    logic [7:0]  alucontrolM;
    logic [31:0] addrM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        saddrerrM;
    logic [31:0] badvaddrM;
    logic        stall_st;
    logic        st_done;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;

    smem_store_unit #(
        .AW(32), .DW(32),
        .SB_CONTROL(OP_SB), .SH_CONTROL(OP_SH), .SW_CONTROL(OP_SW)
    ) dut (
        .clk(clk), .rst(rst),
        .store_validM(store_validM), .alucontrolM(alucontrolM),
        .addrM(addrM), .writedataM(writedataM), .flushM(flushM),
        .saddrerrM(saddrerrM), .badvaddrM(badvaddrM),
        .stall_st(stall_st), .st_done(st_done),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: one outstanding write, whether the bus has accepted it, its payload
    bit          m_busy = 1'b0;
    bit          m_acc  = 1'b0;
    bit          m_done = 1'b0;
    logic [1:0]  m_size  = '0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    bit          m_stall_last = 1'b0;
    int          m_done_cnt = 0;
    int          dut_done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned op_bytes(input logic [7:0] op);
        if (op == OP_SB) return 1;
        if (op == OP_SH) return 2;
        return 4;
    endfunction

    // Expected payload from the store rules, written as arithmetic on byte positions
    task automatic payload(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                           output logic [1:0] sz, output logic [31:0] wdat, output logic [3:0] st);
        int unsigned k;
        k = a % 4;
        if (op == OP_SB) begin
            sz   = 2'd0;
            wdat = 32'(wd[7:0]) * 32'h0101_0101;
            st   = 4'(1 << (3 - k));
        end else if (op == OP_SH) begin
            sz   = 2'd1;
            wdat = 32'(wd[15:0]) * 32'h0001_0001;
            st   = (k >= 2) ? 4'b0011 : 4'b1100;
        end else begin
            sz   = 2'd2;
            wdat = wd;
            st   = 4'b1111;
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        bit          is_st, mis, e_err, e_start, e_stall, e_req;
        logic [31:0] e_bad;
        logic [1:0]  n_size;
        logic [31:0] n_wdata;
        logic [3:0]  n_wstrb;
        if (chk_en) begin
            is_st   = (alucontrolM == OP_SB) || (alucontrolM == OP_SH) || (alucontrolM == OP_SW);
            mis     = is_st && ((addrM % op_bytes(alucontrolM)) != 0);
            e_err   = store_validM && is_st && mis && !flushM;
            e_bad   = e_err ? addrM : 32'h0;
            e_start = !m_busy && store_validM && is_st && !mis && !flushM;
            e_req   = m_busy && !m_acc;
            if (rst)                 e_stall = e_start;
            else if (e_start)        e_stall = 1'b1;
            else if (m_busy && !m_acc) e_stall = !(data_addr_ok && data_data_ok) && !flushM;
            else if (m_busy)         e_stall = !data_data_ok;
            else                     e_stall = 1'b0;

            chk("saddrerr", 32'(saddrerrM), 32'(e_err));
            chk("badvaddr", badvaddrM, e_bad);
            chk("stall", 32'(stall_st), 32'(e_stall));
            chk("st_done", 32'(st_done), 32'(m_done));
            chk("data_req", 32'(data_req), 32'(e_req));
            chk("data_wr", 32'(data_wr), 32'(e_req));
            chk("data_size", 32'(data_size), 32'(m_size));
            chk("data_addr", data_addr, m_addr);
            chk("data_wdata", data_wdata, m_wdata);
            chk("data_wstrb", 32'(data_wstrb), 32'(m_wstrb));

            dut_done_cnt += int'(st_done);
            m_done_cnt   += int'(m_done);
            m_stall_last  = e_stall;

            if (rst) begin
                m_busy = 0; m_acc = 0; m_done = 0;
                m_size = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
            end else begin
                m_done = 0;
                if (!m_busy) begin
                    if (e_start) begin
                        payload(alucontrolM, addrM, writedataM, n_size, n_wdata, n_wstrb);
                        m_busy = 1; m_acc = 0;
                        m_size = n_size; m_addr = addrM; m_wdata = n_wdata; m_wstrb = n_wstrb;
                    end
                end else if (!m_acc) begin
                    if (data_addr_ok && data_data_ok) begin
                        m_busy = 0; m_done = 1;
                    end else if (data_addr_ok) begin
                        m_acc = 1;
                    end else if (flushM) begin
                        m_busy = 0;
                    end
                end else if (data_data_ok) begin
                    m_busy = 0; m_acc = 0; m_done = 1;
                end
            end
        end
    end

    task automatic drv(input logic v, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic fl, input logic ao,
                       input logic dk, input logic r);
        @(posedge clk);
        #1;
        store_validM = v; alucontrolM = op; addrM = a; writedataM = wd;
        flushM = fl; data_addr_ok = ao; data_data_ok = dk; rst = r;
        @(negedge clk);
    endtask

    task automatic idle(input logic dk);
        drv(1'b0, OP_NO, 32'h0, 32'h0, 1'b0, 1'b0, dk, 1'b0);
    endtask

    initial begin
        int done6;
        logic       h_v;
        logic [7:0] h_op;
        logic [31:0] h_a, h_wd;
        int unsigned r;

        rst = 1'b1; store_validM = 1'b0; alucontrolM = OP_NO; addrM = '0;
        writedataM = '0; flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req", 32'(data_req), 32'h0);
        chk("rst_wstrb", 32'(data_wstrb), 32'h0);
        chk("rst_stall", 32'(stall_st), 32'h0);
        idle(1'b0);

        // 1: SB at offset 3, immediate accept and completion
        drv(1, OP_SB, 32'h1003, 32'h0000_00A5, 0, 0, 0, 0);
        chk("t1_stall0", 32'(stall_st), 32'h1);
        drv(1, OP_SB, 32'h1003, 32'h0000_00A5, 0, 1, 1, 0);
        chk("t1_req", 32'(data_req), 32'h1);
        chk("t1_wstrb", 32'(data_wstrb), 32'h1);
        chk("t1_wdata", data_wdata, 32'hA5A5_A5A5);
        chk("t1_size", 32'(data_size), 32'h0);
        idle(1'b0);
        chk("t1_done", 32'(st_done), 32'h1);
        idle(1'b0);
        chk("t1_done_pulse", 32'(st_done), 32'h0);

        // 2: SH accepted in first REQ cycle, data_ok three cycles later
        drv(1, OP_SH, 32'h2000, 32'h0000_1234, 0, 0, 0, 0);
        drv(1, OP_SH, 32'h2000, 32'h0000_1234, 0, 1, 0, 0);
        chk("t2_wstrb", 32'(data_wstrb), 32'hC);
        chk("t2_wdata", data_wdata, 32'h1234_1234);
        chk("t2_size", 32'(data_size), 32'h1);
        drv(1, OP_SH, 32'h2000, 32'h0000_1234, 0, 0, 0, 0);
        chk("t2_wait_stall", 32'(stall_st), 32'h1);
        drv(1, OP_SH, 32'h2000, 32'h0000_1234, 0, 0, 0, 0);
        drv(1, OP_SH, 32'h2000, 32'h0000_1234, 0, 0, 1, 0);
        chk("t2_release", 32'(stall_st), 32'h0);
        idle(1'b0);
        chk("t2_done", 32'(st_done), 32'h1);

        // 3: misaligned stores never issue
        drv(1, OP_SW, 32'h3002, 32'h0, 0, 0, 0, 0);
        chk("t3_err_sw", 32'(saddrerrM), 32'h1);
        chk("t3_bad_sw", badvaddrM, 32'h3002);
        drv(1, OP_SH, 32'h3001, 32'h0, 0, 0, 0, 0);
        chk("t3_bad_sh", badvaddrM, 32'h3001);
        idle(1'b0);
        chk("t3_noreq", 32'(data_req), 32'h0);

        // 4a: flush before accept cancels; 4b: flush after accept is ignored
        drv(1, OP_SW, 32'h4000, 32'hDEAD_BEEF, 0, 0, 0, 0);
        drv(1, OP_SW, 32'h4000, 32'hDEAD_BEEF, 1, 0, 0, 0);
        chk("t4_wdata", data_wdata, 32'hDEAD_BEEF);
        idle(1'b0);
        chk("t4_cancel", 32'(data_req), 32'h0);
        idle(1'b0);
        chk("t4_nodone", 32'(st_done), 32'h0);
        drv(1, OP_SW, 32'h4000, 32'hDEAD_BEEF, 0, 0, 0, 0);
        drv(1, OP_SW, 32'h4000, 32'hDEAD_BEEF, 0, 1, 0, 0);
        drv(1, OP_SW, 32'h4000, 32'hDEAD_BEEF, 1, 0, 0, 0);
        chk("t4_wait_flush", 32'(stall_st), 32'h1);
        drv(1, OP_SW, 32'h4000, 32'hDEAD_BEEF, 0, 0, 1, 0);
        idle(1'b0);
        chk("t4_done", 32'(st_done), 32'h1);

        // 5: reset while waiting for data_ok
        drv(1, OP_SH, 32'h6002, 32'h0000_BEEF, 0, 0, 0, 0);
        drv(1, OP_SH, 32'h6002, 32'h0000_BEEF, 0, 1, 0, 0);
        drv(1, OP_SH, 32'h6002, 32'h0000_BEEF, 0, 0, 0, 0);
        drv(1, OP_SH, 32'h6002, 32'h0000_BEEF, 0, 0, 0, 1);
        chk("t5_rst_stall", 32'(stall_st), 32'h0);
        idle(1'b0);
        chk("t5_wdata0", data_wdata, 32'h0);
        chk("t5_addr0", data_addr, 32'h0);
        idle(1'b1);
        idle(1'b0);
        chk("t5_stale_ok", 32'(st_done), 32'h0);
        drv(1, OP_SB, 32'h7002, 32'h0000_003C, 0, 0, 0, 0);
        drv(1, OP_SB, 32'h7002, 32'h0000_003C, 0, 1, 1, 0);
        chk("t5_sb_wstrb", 32'(data_wstrb), 32'h2);
        chk("t5_sb_wdata", data_wdata, 32'h3C3C_3C3C);
        idle(1'b0);
        chk("t5_sb_done", 32'(st_done), 32'h1);

        // 6: back-to-back SW then SB
        done6 = 0;
        drv(1, OP_SW, 32'h5000, 32'h1122_3344, 0, 0, 0, 0);
        done6 += int'(st_done);
        drv(1, OP_SW, 32'h5000, 32'h1122_3344, 0, 1, 1, 0);
        done6 += int'(st_done);
        drv(1, OP_SB, 32'h5001, 32'h0000_0077, 0, 0, 0, 0);
        done6 += int'(st_done);
        chk("t6_start2", 32'(stall_st), 32'h1);
        drv(1, OP_SB, 32'h5001, 32'h0000_0077, 0, 1, 1, 0);
        done6 += int'(st_done);
        chk("t6_wstrb", 32'(data_wstrb), 32'h4);
        idle(1'b0);
        done6 += int'(st_done);
        idle(1'b0);
        done6 += int'(st_done);
        chk("t6_done_cnt", 32'(done6), 32'd2);

        // Randomized pipeline: an instruction is held while the model says stall
        h_v = 0; h_op = OP_NO; h_a = '0; h_wd = '0;
        for (int c = 0; c < 4000; c++) begin
            if (!m_stall_last) begin
                h_v = ($urandom % 4) != 0;
                r   = $urandom % 4;
                h_op = (r == 0) ? OP_SB : (r == 1) ? OP_SH : (r == 2) ? OP_SW : OP_NO;
                h_a  = $urandom;
                h_wd = $urandom;
            end
            drv(h_v, h_op, h_a, h_wd, ($urandom % 10) == 0, 1'($urandom % 2),
                1'($urandom % 2), ($urandom % 80) == 0);
        end
        idle(1'b0);
        idle(1'b0);
        chk("done_count", 32'(dut_done_cnt), 32'(m_done_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
